button_conditioner: RTL and testbench

//  Input-side counterpart to the display path. Conditions the four raw board push-buttons:

---
 rtl/reaction_timer_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 34 +++
 rtl/btn_debounce_channel.sv | 101 ++++++++++
 rtl/button_conditioner.sv | 61 ++++++
 tb/tb_button_conditioner.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared constants and helpers for the reaction-timer board design.
//
// Contents:
//   NUM_BTNS_DEFAULT  number of board push-buttons
//   CLK_HZ_DEFAULT    board system clock frequency in Hz
//   ms_to_cycles()    milliseconds to clock cycles. The clock dividers use it too.
package reaction_timer_pkg;

    localparam int NUM_BTNS_DEFAULT = 4;
    localparam int CLK_HZ_DEFAULT   = 100_000_000;

    // Divide first so that large clock rates stay inside 32-bit range.
    function automatic int ms_to_cycles(input int hz, input int ms);
        return (hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the timer/state logic.
//
// Signals:
//   btn_raw      raw asynchronous pin levels, 1 = pressed (driven by master)
//   btn_level    debounced level per button
//   btn_press    1-cycle pulse on an accepted 0->1 transition
//   btn_release  1-cycle pulse on an accepted 1->0 transition
//   any_press    OR of btn_press
//   btn_long     1-cycle long-press pulse. It is 0 unless BTN_LONGPRESS_EN is defined.
// Modports:
//   master  pin side / consumer: drives btn_raw and observes the conditioned outputs
//   slave   the conditioner: reads btn_raw and drives the conditioned outputs
interface button_conditioner_if
    import reaction_timer_pkg::*;
#(
    parameter int NUM_BTNS = NUM_BTNS_DEFAULT
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_release;
    logic                any_press;
    logic [NUM_BTNS-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, any_press, btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, any_press, btn_long
    );
endinterface

// File: rtl/btn_debounce_channel.sv
// One push-button channel. It synchronizes the raw pin and debounces the
// synchronized value. It outputs a registered level plus press and release pulses.
// When BTN_LONGPRESS_EN is defined, a hold counter also raises a single
// long-press pulse per hold.
//
// Ports:
//   clk          system clock
//   ck_rst       synchronous reset, active-high. It clears every flop in the channel.
//   btn_raw      asynchronous raw pin, 1 = pressed
//   btn_level    debounced level
//   btn_press    1-cycle pulse on an accepted 0->1 transition
//   btn_release  1-cycle pulse on an accepted 1->0 transition
//   btn_long     1-cycle pulse after LONG_CYCLES of held level. It is 0 without BTN_LONGPRESS_EN.
module btn_debounce_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int LONG_CYCLES = 20
) (
    input  logic clk,
    input  logic ck_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("btn_debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 2) begin : g_db_chk
        $error("btn_debounce_channel: DB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_long_chk
        $error("btn_debounce_channel: LONG_CYCLES must be >= 1");
    end

    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;
    logic [CW-1:0]          cnt;

    assign s = sync_p0[SYNC_STAGES-1];

    // Stage p0: synchronizer chain. The raw pin enters bit 0 and s is the last flop.
    // The debounce stage that follows requires DB_CYCLES consecutive disagreeing
    // samples. A single agreeing sample restarts the count. On acceptance the counter
    // is cleared, so it never has to hold DB_CYCLES itself.
    always_ff @(posedge clk) begin
        if (ck_rst) begin
            sync_p0     <= '0;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync_p0     <= {sync_p0[SYNC_STAGES-2:0], btn_raw};
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (s == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_level   <= s;
                cnt         <= '0;
                btn_press   <= s;
                btn_release <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam int            HW        = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold;

    // The counter saturates, so HOLD_FIRE is passed only once per hold.
    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    // Hold stage: counts cycles of debounced level high.
    always_ff @(posedge clk) begin
        if (ck_rst) begin
            hold     <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= btn_level && (hold == HOLD_FIRE);
            hold     <= btn_level ? sat_inc(hold) : '0;
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board push-buttons before they reach the timer and state
// FSMs. Each button goes through its own synchronizer/debouncer channel.
// any_press merges the per-button press pulses.
// Optional feature macro: BTN_LONGPRESS_EN enables the long-press pulse. Without
// it, btn_long is tied to 0.
//
// Ports:
//   clk     system clock
//   ck_rst  synchronous reset, active-high
//   bus     button_conditioner_if.slave. It carries btn_raw in, and btn_level,
//           btn_press, btn_release, any_press and btn_long out.
module button_conditioner
    import reaction_timer_pkg::*;
#(
    parameter int NUM_BTNS    = NUM_BTNS_DEFAULT,
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = 10,
    parameter int SYNC_STAGES = 2,
    parameter int LONG_MS     = 1000
) (
    input  logic                 clk,
    input  logic                 ck_rst,
    button_conditioner_if.slave  bus
);

    localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);

    if (DB_CYCLES < 2) begin : g_db_chk
        $error("button_conditioner: DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS must be >= 2");
    end

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] rel;
    logic [NUM_BTNS-1:0] lng;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .ck_rst      (ck_rst),
            .btn_raw     (bus.btn_raw[i]),
            .btn_level   (level[i]),
            .btn_press   (press[i]),
            .btn_release (rel[i]),
            .btn_long    (lng[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_long    = lng;
    // The press pulses are already registered, so this OR lines up with them cycle for cycle.
    assign bus.any_press   = |press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with CLK_HZ=1000, DEBOUNCE_MS=4 and LONG_MS=20.
// This gives DB_CYCLES=4 and LONG_CYCLES=20.
// The stimulus queues each expected pulse event with the cycle it must appear in.
// A negedge monitor takes every cycle with a nonzero pulse output and matches it
// against the head of the queue.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic ck_rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner_if #(.NUM_BTNS(4)) bus ();

    button_conditioner #(
        .NUM_BTNS    (4),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .SYNC_STAGES (2),
        .LONG_MS     (20)
    ) dut (
        .clk    (clk),
        .ck_rst (ck_rst),
        .bus    (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] level;
        logic       any;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l, input logic [3:0] lv, input logic a);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.level = lv; e.any = a;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the queued event for this exact cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_fails++;
            $display("FAIL missing_event: expected pulse at cycle %0d, not seen by cycle %0d",
                     exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if ((bus.btn_press | bus.btn_release | bus.btn_long) != 4'b0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("ev_press",   32'(bus.btn_press),   32'(e.press));
                check("ev_release", 32'(bus.btn_release), 32'(e.rel));
                check("ev_long",    32'(bus.btn_long),    32'(e.lng));
                check("ev_level",   32'(bus.btn_level),   32'(e.level));
                check("ev_any",     32'(bus.any_press),   32'(e.any));
            end else begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_event: press=%b release=%b long=%b, required none (cycle %0d)",
                         bus.btn_press, bus.btn_release, bus.btn_long, cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   32'(bus.btn_level),   32'h0);
        check({tag, "_press"},   32'(bus.btn_press),   32'h0);
        check({tag, "_release"}, 32'(bus.btn_release), 32'h0);
        check({tag, "_any"},     32'(bus.any_press),   32'h0);
        check({tag, "_long"},    32'(bus.btn_long),    32'h0);
    endtask

    initial begin
        int c;
        bus.btn_raw = 4'b0000;
        ck_rst = 1'b1;
        tick(3);
        check_all_zero("reset");
        ck_rst = 1'b0;
        tick(2);

        // 1: single press on channel 0, then release.
        bus.btn_raw[0] = 1'b1;
        c = cyc;
        push(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        tick(5);
        check("t1_level_early", 32'(bus.btn_level), 32'h0);
        tick(1);
        check("t1_level_on", 32'(bus.btn_level), 32'h1);
        tick(4);
        bus.btn_raw[0] = 1'b0;
        push(cyc + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        tick(10);

        // 2: bounce 1,0,1,0 on channel 1, then settle high.
        bus.btn_raw[1] = 1'b1; tick(1);
        bus.btn_raw[1] = 1'b0; tick(1);
        bus.btn_raw[1] = 1'b1; tick(1);
        bus.btn_raw[1] = 1'b0; tick(1);
        bus.btn_raw[1] = 1'b1;
        push(cyc + 6, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1);
        tick(10);
        bus.btn_raw[1] = 1'b0;
        push(cyc + 6, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        tick(10);

        // 3: 3-cycle glitch on channel 2 must be rejected.
        bus.btn_raw[2] = 1'b1;
        tick(3);
        bus.btn_raw[2] = 1'b0;
        tick(10);
        check("t3_level", 32'(bus.btn_level), 32'h0);

        // 4: simultaneous press and release on channels 1 and 3.
        bus.btn_raw = 4'b1010;
        push(cyc + 6, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 1'b1);
        tick(7);
        check("t4_any_single", 32'(bus.any_press), 32'h0);
        tick(3);
        bus.btn_raw = 4'b0000;
        push(cyc + 6, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0);
        tick(10);

        // 5: reset asserted mid-debounce while channel 3 is held.
        bus.btn_raw[3] = 1'b1;
        tick(4);
        ck_rst = 1'b1;
        tick(2);
        check_all_zero("t5_in_reset");
        ck_rst = 1'b0;
        push(cyc + 6, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        tick(10);
        bus.btn_raw[3] = 1'b0;
        push(cyc + 6, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0);
        tick(10);

        // 6: hold channel 0 for 40 cycles.
        bus.btn_raw[0] = 1'b1;
        c = cyc;
        push(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
`ifdef BTN_LONGPRESS_EN
        push(c + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);
`endif
        tick(26);
`ifdef BTN_LONGPRESS_EN
        check("t6_long_at_20", 32'(bus.btn_long), 32'h1);
`else
        check("t6_long_at_20", 32'(bus.btn_long), 32'h0);
`endif
        tick(14);
        bus.btn_raw[0] = 1'b0;
        push(cyc + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        tick(12);

        while (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL leftover_event: expected pulse at cycle %0d never seen", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
